grf_write_arbiter: RTL and testbench

Shares the single GRF write port between the in-order pipeline writeback (requester A, fixed priority) and a multi-cycle unit such as a multiply/divide or slow load unit (requester B, valid/ready). B writes are buffered in a small FIFO and drained into the GRF in cycles where A is idle. A starvation guard stalls A when B waits too long, and a per-register pending mask lets decode logic interlock on registers with queued B writes. The block sits between the writeback stage and the GRF write inputs (write enable, write address, write data).

---
 rtl/grf_write_arbiter.sv | 132 +++++++++++++
 tb/tb_grf_write_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: shares the single GRF write port between the in-order
// writeback path (A, fixed priority, no handshake) and a multi-cycle unit
// (B, valid/ready) whose writes are queued in a small FIFO.
// Optional macro GRF_ARB_SCOREBOARD_EN enables the per-register pending mask;
// without it pend_mask is tied to zero.
module grf_write_arbiter #(
    parameter int DEPTH      = 4,   // power of two, >= 2
    parameter int STARVE_MAX = 3    // 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_wdata,
    output logic [31:0] pend_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    SMAX     = 4'(STARVE_MAX);

    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } fifoEntry_t;

    fifoEntry_t      fifo [DEPTH];
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic [3:0]      starveCnt;

    fifoEntry_t head;
    logic empty, full, push, aWrite, headUse, headDead, pop, blocked;

    assign head     = fifo[rdPtr];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign b_ready  = !full;
    assign push     = b_valid && !full;
    // A write to r0 is a no-op and never claims the port
    assign aWrite   = a_we && (a_addr != 5'd0);
    // A head that was killed, or that targets r0, is dropped without a write
    assign headUse  = !empty && head.live && (head.addr != 5'd0);
    assign headDead = !empty && !headUse;
    assign pop      = headDead || (headUse && !aWrite);
    assign blocked  = headUse && aWrite;

    // FIFO storage: A writes kill older matching entries; a same-edge push is younger and survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (aWrite) begin
                for (int i = 0; i < DEPTH; i++)
                    if (fifo[i].addr == a_addr) fifo[i].live <= 1'b0;
            end
            if (push) begin
                fifo[wrPtr] <= {1'b1, b_addr, b_data};
                wrPtr       <= wrPtr + PW'(1);
            end
            if (pop) rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // GRF write register: A first, then a usable head, otherwise idle with address/data held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grf_we    <= 1'b0;
            grf_addr  <= '0;
            grf_wdata <= '0;
        end else if (aWrite) begin
            grf_we    <= 1'b1;
            grf_addr  <= a_addr;
            grf_wdata <= a_data;
        end else if (headUse) begin
            grf_we    <= 1'b1;
            grf_addr  <= head.addr;
            grf_wdata <= head.data;
        end else begin
            grf_we    <= 1'b0;
        end
    end

    // Starvation guard: count edges the live head loses to A; stall A once the limit is hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
            a_stall   <= 1'b0;
        end else if (pop) begin
            starveCnt <= '0;
            a_stall   <= 1'b0;
        end else if (empty) begin
            starveCnt <= '0;
        end else if (blocked && starveCnt != SMAX) begin
            starveCnt <= starveCnt + 4'd1;
            if (starveCnt + 4'd1 == SMAX) a_stall <= 1'b1;
        end
    end

`ifdef GRF_ARB_SCOREBOARD_EN
    // Pending mask: live occupied slots mark their destination; r0 never reported
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(i) - rdPtr) < count) && fifo[i].live)
                pend_mask[fifo[i].addr] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end
`else
    assign pend_mask = 32'h0;
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Randomized + directed bench for grf_write_arbiter against a queue-based model.
module tb_grf_write_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic [31:0] pend_mask;

    grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of pending B writes plus the expected output registers
    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
    } ent_t;

    ent_t      q[$];
    bit        mWe;
    bit [4:0]  mAddr;
    bit [31:0] mData;
    int        mCnt;
    bit        mStall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expMask();
        logic [31:0] m;
        m = 32'h0;
`ifdef GRF_ARB_SCOREBOARD_EN
        foreach (q[i]) if (q[i].live && q[i].addr != 0) m[q[i].addr] = 1'b1;
`endif
        return m;
    endfunction

    task automatic modelReset();
        q.delete();
        mWe = 0; mAddr = 0; mData = 0; mCnt = 0; mStall = 0;
    endtask

    // Apply the arbitration rules for one clock edge using the driven inputs
    task automatic modelEdge();
        bit aw, rdy, useHead, dead, popped;
        aw      = a_we && (a_addr != 0);
        rdy     = q.size() < DEPTH;
        useHead = 0;
        dead    = 0;
        popped  = 0;
        if (q.size() > 0) begin
            useHead = q[0].live && (q[0].addr != 0);
            dead    = !useHead;
        end
        if (aw) begin
            mWe = 1; mAddr = a_addr; mData = a_data;
        end else if (useHead) begin
            mWe = 1; mAddr = q[0].addr; mData = q[0].data;
        end else begin
            mWe = 0;
        end
        if (dead || (useHead && !aw)) begin
            q.delete(0);
            popped = 1;
        end
        if (popped) begin
            mCnt = 0; mStall = 0;
        end else if (useHead && aw) begin
            if (mCnt < STARVE_MAX) mCnt++;
            if (mCnt == STARVE_MAX) mStall = 1;
        end else if (q.size() == 0) begin
            mCnt = 0;
        end
        if (aw) foreach (q[i]) if (q[i].addr == a_addr) q[i].live = 0;
        if (b_valid && rdy) q.push_back('{1'b1, b_addr, b_data});
    endtask

    task automatic checkOut(input string tag);
        chk({tag, ".we"},    32'(grf_we),    32'(mWe));
        chk({tag, ".addr"},  32'(grf_addr),  32'(mAddr));
        chk({tag, ".data"},  grf_wdata,      mData);
        chk({tag, ".stall"}, 32'(a_stall),   32'(mStall));
        chk({tag, ".ready"}, 32'(b_ready),   32'(q.size() < DEPTH));
        chk({tag, ".pend"},  pend_mask,      expMask());
    endtask

    // Drive at negedge, clock once, update model, compare just after the edge
    task automatic step(input bit aWe, input bit [4:0] aA, input bit [31:0] aD,
                        input bit bV, input bit [4:0] bA, input bit [31:0] bD,
                        input string tag);
        a_we = aWe; a_addr = aA; a_data = aD;
        b_valid = bV; b_addr = bA; b_data = bD;
        @(posedge clk);
        modelEdge();
        #1;
        checkOut(tag);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst = 1;
        a_we = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        modelReset();
        #12;
        checkOut("reset");
        @(negedge clk);
        rst = 0;

        // Single B write with A idle: visible after the second edge
        step(0, 0, 0, 1, 5, 32'h1234, "b1push");
        step(0, 0, 0, 0, 0, 0,        "b1write");
        idle(1, "b1idle");

        // A hogs the port while B fills the FIFO; starvation stalls A
        for (int i = 1; i <= 4; i++) step(1, 7, 32'h700 + i, 1, 5'(i), 32'hB0 + i, "fill");
        step(0, 0, 0, 1, 9, 32'hDEAD, "fullpush");
        idle(6, "drain");

        // Kill: queued B write to r9 overtaken by A
        step(0, 0, 0, 1, 9, 32'hAAAA, "kpush");
        step(1, 9, 32'hBBBB, 0, 0, 0, "kill");
        idle(2, "kidle");

        // Same-edge A and B to r3: B is younger and lands last
        step(1, 3, 32'h3333, 1, 3, 32'hCCCC, "same");
        idle(2, "sameidle");

        // A write to r0 does not block a waiting head
        step(1, 8, 32'h8888, 1, 6, 32'h6666, "r0q");
        step(1, 0, 32'h0F0F, 0, 0, 0,        "r0a");
        idle(1, "r0idle");

        // B entry to r0 is dropped silently
        step(0, 0, 0, 1, 0, 32'h5555, "b0push");
        idle(2, "b0idle");

        // Randomized traffic; A honours a_stall using the model's view
        for (int n = 0; n < 1500; n++) begin
            bit aWe, bV;
            aWe = !mStall && ($urandom_range(0, 1) == 1);
            bV  = ($urandom_range(0, 9) < 6);
            step(aWe, 5'($urandom_range(0, 7)), $urandom,
                 bV, 5'($urandom_range(0, 7)), $urandom, "rand");
        end
        idle(DEPTH + 2, "rdrain");

        // Asynchronous reset with three entries queued and grf_we high
        for (int i = 1; i <= 3; i++) step(1, 20, 32'h2000 + i, 1, 5'(10 + i), 32'hE0 + i, "rfill");
        #2;
        rst = 1;
        #1;
        chk("arst.we",    32'(grf_we),   32'h0);
        chk("arst.addr",  32'(grf_addr), 32'h0);
        chk("arst.data",  grf_wdata,     32'h0);
        chk("arst.stall", 32'(a_stall),  32'h0);
        chk("arst.ready", 32'(b_ready),  32'h1);
        chk("arst.pend",  pend_mask,     32'h0);
        modelReset();
        a_we = 0; b_valid = 0;
        @(negedge clk);
        rst = 0;
        idle(5, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
